// File: rtl/datapath_sequencer.sv
// datapath_sequencer
// Run-level controller for the single-cycle datapath. A run proceeds as:
//   1. load the selected program image (memory reset),
//   2. reset PC, SP and the register bank,
//   3. execute until halt or the watchdog limit,
//   4. report completion, the RUN cycle count and the captured write_data2.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset; CPU resets held, waiting for start
// MEM_INIT | dp_mem_reset held for MEM_RST_CYCLES cycles (image load)
// CPU_INIT | one cycle of CPU resets only, memory image already loaded
// RUN      | dp_en high, counting cycles, watching halt and the watchdog
// DONE     | stopped; results held, datapath left inspectable
//
// Every output is registered. The output next-values are derived from the
// next state, so an output changes on the same edge as the state it reflects.

module datapath_sequencer #(
  parameter int MEM_RST_CYCLES = 2,
  parameter int MAX_CYCLES     = 4096,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             prog_sel,
  input  logic             halt,
  input  logic [31:0]      dp_data,
  output logic             dp_reset,
  output logic             dp_mem_reset,
  output logic             dp_pc_reset,
  output logic             dp_sp_reset,
  output logic             dp_gcd,
  output logic             dp_booth,
  output logic             dp_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [31:0]      result,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MEM_INIT = 3'd1,
    S_CPU_INIT = 3'd2,
    S_RUN      = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  // Memory-init timer is a down-counter loaded on entry; terminal count is 0.
  localparam int MEM_W = (MEM_RST_CYCLES > 1) ? $clog2(MEM_RST_CYCLES) : 1;
  localparam logic [MEM_W-1:0] MEM_LOAD = MEM_W'(MEM_RST_CYCLES - 1);

  // The watchdog fires in the RUN cycle whose increment makes cycles reach
  // MAX_CYCLES, i.e. when the current count is one below the limit.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic [MEM_W-1:0] mem_cnt_q, mem_cnt_d;

  logic             start_acc;
  logic             wd_stop;

  logic             dp_reset_q, dp_reset_d;
  logic             dp_mem_reset_q, dp_mem_reset_d;
  logic             dp_pc_reset_q, dp_pc_reset_d;
  logic             dp_sp_reset_q, dp_sp_reset_d;
  logic             dp_gcd_q, dp_gcd_d;
  logic             dp_booth_q, dp_booth_d;
  logic             dp_en_q, dp_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [31:0]      result_q, result_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  // State register and memory-init timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mem_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_cnt_q <= mem_cnt_d;
    end
  end

  // Next-state logic; also flags an accepted start and a watchdog stop.
  always_comb begin
    state_d   = state_q;
    mem_cnt_d = mem_cnt_q;
    start_acc = 1'b0;
    wd_stop   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_MEM_INIT;
          mem_cnt_d = MEM_LOAD;
          start_acc = 1'b1;
        end
      end
      S_MEM_INIT: begin
        if (mem_cnt_q == '0) begin
          state_d = S_CPU_INIT;
        end else begin
          mem_cnt_d = mem_cnt_q - 1'b1;
        end
      end
      S_CPU_INIT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        // halt takes priority over the watchdog in the same cycle
        if (halt) begin
          state_d = S_DONE;
        end else if (cycles_q == WD_LAST) begin
          state_d = S_DONE;
          wd_stop = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next-values, derived from the next state and the run bookkeeping.
  always_comb begin
    dp_reset_d     = (state_d == S_IDLE) || (state_d == S_MEM_INIT) ||
                     (state_d == S_CPU_INIT);
    dp_pc_reset_d  = dp_reset_d;
    dp_sp_reset_d  = dp_reset_d;
    dp_mem_reset_d = (state_d == S_MEM_INIT);
    dp_en_d        = (state_d == S_RUN);
    busy_d         = (state_d == S_MEM_INIT) || (state_d == S_CPU_INIT) ||
                     (state_d == S_RUN);
    done_d         = (state_d == S_DONE);

    dp_gcd_d   = dp_gcd_q;
    dp_booth_d = dp_booth_q;
    timeout_d  = timeout_q;
    result_d   = result_q;
    cycles_d   = cycles_q;

    if (start_acc) begin
      // one-hot image select, latched only when a start is accepted
      dp_gcd_d   = ~prog_sel;
      dp_booth_d = prog_sel;
      timeout_d  = 1'b0;
      result_d   = '0;
      cycles_d   = '0;
    end

    if (state_q == S_RUN) begin
      // the stopping cycle is a RUN cycle too, so it is counted
      cycles_d = cycles_q + CNT_W'(1);
      if (state_d == S_DONE) begin
        result_d  = dp_data;
        timeout_d = wd_stop;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_reset_q     <= 1'b1;
      dp_mem_reset_q <= 1'b0;
      dp_pc_reset_q  <= 1'b1;
      dp_sp_reset_q  <= 1'b1;
      dp_gcd_q       <= 1'b0;
      dp_booth_q     <= 1'b0;
      dp_en_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      result_q       <= '0;
      cycles_q       <= '0;
    end else begin
      dp_reset_q     <= dp_reset_d;
      dp_mem_reset_q <= dp_mem_reset_d;
      dp_pc_reset_q  <= dp_pc_reset_d;
      dp_sp_reset_q  <= dp_sp_reset_d;
      dp_gcd_q       <= dp_gcd_d;
      dp_booth_q     <= dp_booth_d;
      dp_en_q        <= dp_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      result_q       <= result_d;
      cycles_q       <= cycles_d;
    end
  end

  assign dp_reset     = dp_reset_q;
  assign dp_mem_reset = dp_mem_reset_q;
  assign dp_pc_reset  = dp_pc_reset_q;
  assign dp_sp_reset  = dp_sp_reset_q;
  assign dp_gcd       = dp_gcd_q;
  assign dp_booth     = dp_booth_q;
  assign dp_en        = dp_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign result       = result_q;
  assign cycles       = cycles_q;

endmodule
